// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: IF read port, LS read/write port, memory port.
// Modports: slave (arbiter side), master (requesters + memory model side).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;

    logic              ls_req_i;
    logic              ls_we_i;
    logic [ADDR_W-1:0] ls_addr_i;
    logic [DATA_W-1:0] ls_wdata_i;
    logic [BE_W-1:0]   ls_be_i;
    logic              ls_gnt_o;
    logic              ls_rvalid_o;
    logic [DATA_W-1:0] ls_rdata_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [BE_W-1:0]   mem_be_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_be_i,
        output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        input  mem_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_be_i,
        input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and the
// load/store unit (LS); one read in flight, fixed-latency read return.
// Ports: clk_i, rst_i (sync, active-high), bus (mem_port_arbiter_if.slave).
// Optional: define ARB_ROUND_ROBIN_EN for alternating priority on
// simultaneous requests (default: LS beats IF).
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    mem_port_arbiter_if.slave    bus
);
    typedef enum logic {IDLE, RD_WAIT} state_t;

    localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

    state_t     state;
    logic [2:0] cnt;
    logic       owner;      // 1 = LS, 0 = IF
    logic       any_req;
    logic       grant;
    logic       pick_ls;
    logic       ls_write;
    logic       rd_done;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_winner;      // 1 = LS, 0 = IF

    // On a tie, favour whoever did not win the previous grant.
    assign pick_ls = bus.ls_req_i && (!bus.if_req_i || !last_winner);
`else
    assign pick_ls = bus.ls_req_i;
`endif

    assign any_req  = bus.if_req_i | bus.ls_req_i;
    assign grant    = !rst_i && (state == IDLE) && any_req;
    assign ls_write = pick_ls && bus.ls_we_i;
    assign rd_done  = !rst_i && (state == RD_WAIT) && (cnt == 3'd0);

    assign bus.if_gnt_o    = grant && !pick_ls;
    assign bus.ls_gnt_o    = grant && pick_ls;
    assign bus.if_rvalid_o = rd_done && !owner;
    assign bus.ls_rvalid_o = rd_done && owner;
    assign bus.if_rdata_o  = bus.mem_rdata_i;
    assign bus.ls_rdata_o  = bus.mem_rdata_i;

    assign bus.mem_req_o   = grant;
    assign bus.mem_we_o    = grant && ls_write;
    assign bus.mem_addr_o  = !grant  ? '0 :
                             pick_ls ? bus.ls_addr_i : bus.if_addr_i;
    assign bus.mem_wdata_o = (grant && ls_write) ? bus.ls_wdata_i : '0;
    assign bus.mem_be_o    = !grant   ? '0 :
                             ls_write ? bus.ls_be_i : '1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= 3'd0;
            owner <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_winner <= 1'b1;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant) begin
`ifdef ARB_ROUND_ROBIN_EN
                        last_winner <= pick_ls;
`endif
                        // Writes finish in the grant cycle; only reads wait.
                        if (!ls_write) begin
                            owner <= pick_ls;
                            cnt   <= CNT_INIT;
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt == 3'd0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (RD_LAT=2 instance)
// plus a hand-written RD_LAT=1 back-to-back read sequence.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (a)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (b)
    );

    typedef struct {
        logic        rst;
        logic        ifr;
        logic [31:0] ifa;
        logic        lsr;
        logic        lswe;
        logic [31:0] lsa;
        logic [31:0] lswd;
        logic [3:0]  lsbe;
        logic [31:0] mrd;
        logic        ifg;
        logic        lsg;
        logic        ifv;
        logic        lsv;
        logic        mreq;
        logic        mwe;
        logic [31:0] maddr;
        logic [3:0]  mbe;
        logic [31:0] mwd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(
        input logic rst, input logic ifr, input logic [31:0] ifa,
        input logic lsr, input logic lswe, input logic [31:0] lsa,
        input logic [31:0] lswd, input logic [3:0] lsbe,
        input logic [31:0] mrd,
        input logic ifg, input logic lsg, input logic ifv, input logic lsv,
        input logic mreq, input logic mwe, input logic [31:0] maddr,
        input logic [3:0] mbe, input logic [31:0] mwd);
        vec_t r;
        r.rst = rst;   r.ifr = ifr;   r.ifa = ifa;
        r.lsr = lsr;   r.lswe = lswe; r.lsa = lsa;
        r.lswd = lswd; r.lsbe = lsbe; r.mrd = mrd;
        r.ifg = ifg;   r.lsg = lsg;   r.ifv = ifv;   r.lsv = lsv;
        r.mreq = mreq; r.mwe = mwe;   r.maddr = maddr;
        r.mbe = mbe;   r.mwd = mwd;
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [73:0] act_b;
        logic [73:0] exp_b;
        logic        chk_addr;
        logic        chk_wd;

        a.if_req_i = 0; a.if_addr_i = 0; a.ls_req_i = 0; a.ls_we_i = 0;
        a.ls_addr_i = 0; a.ls_wdata_i = 0; a.ls_be_i = 0; a.mem_rdata_i = 0;
        b.if_req_i = 0; b.if_addr_i = 0; b.ls_req_i = 0; b.ls_we_i = 0;
        b.ls_addr_i = 0; b.ls_wdata_i = 0; b.ls_be_i = 0; b.mem_rdata_i = 0;

        // reset with requests pending: everything must stay quiet
        vecs.push_back(v(1,1,'h10,1,0,'h20,0,0,0, 0,0,0,0,0,0,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,0,0,0,       0,0,0,0,0,0,0,0,0));
        // IF read, LS waits during RD_WAIT, then LS read
        vecs.push_back(v(0,1,'h10,0,0,0,0,0,0,    1,0,0,0,1,0,'h10,'hF,0));
        vecs.push_back(v(0,0,0,1,0,'h200,0,0,0,   0,0,0,0,0,0,0,0,0));
        vecs.push_back(v(0,0,0,1,0,'h200,0,0,'h13, 0,0,1,0,0,0,0,0,0));
        vecs.push_back(v(0,0,0,1,0,'h200,0,0,0,   0,1,0,0,1,0,'h200,'hF,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,0,       0,0,0,0,0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,'hCAFE0001, 0,0,0,1,0,0,0,0,0));
        // back-to-back byte writes, no rvalid afterwards
        vecs.push_back(v(0,0,0,1,1,'h100,'hDEADBEEF,'h3,0,
                         0,1,0,0,1,1,'h100,'h3,'hDEADBEEF));
        vecs.push_back(v(0,0,0,1,1,'h104,'h12345678,'hC,0,
                         0,1,0,0,1,1,'h104,'hC,'h12345678));
        vecs.push_back(v(0,0,0,0,0,0,0,0,'h55,    0,0,0,0,0,0,0,0,0));
        // reset, then simultaneous IF/LS reads
        vecs.push_back(v(1,1,'h30,1,0,'h40,0,0,0, 0,0,0,0,0,0,0,0,0));
`ifdef ARB_ROUND_ROBIN_EN
        vecs.push_back(v(0,1,'h30,1,0,'h40,0,0,0, 1,0,0,0,1,0,'h30,'hF,0));
        vecs.push_back(v(0,0,0,1,0,'h40,0,0,0,    0,0,0,0,0,0,0,0,0));
        vecs.push_back(v(0,0,0,1,0,'h40,0,0,'h3030, 0,0,1,0,0,0,0,0,0));
        vecs.push_back(v(0,1,'h50,1,0,'h40,0,0,0, 0,1,0,0,1,0,'h40,'hF,0));
        vecs.push_back(v(0,1,'h50,0,0,0,0,0,0,    0,0,0,0,0,0,0,0,0));
        vecs.push_back(v(0,1,'h50,0,0,0,0,0,'h4040, 0,0,0,1,0,0,0,0,0));
`else
        vecs.push_back(v(0,1,'h30,1,0,'h40,0,0,0, 0,1,0,0,1,0,'h40,'hF,0));
        vecs.push_back(v(0,1,'h30,0,0,0,0,0,0,    0,0,0,0,0,0,0,0,0));
        vecs.push_back(v(0,1,'h30,0,0,0,0,0,'h4040, 0,0,0,1,0,0,0,0,0));
        vecs.push_back(v(0,1,'h30,0,0,0,0,0,0,    1,0,0,0,1,0,'h30,'hF,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,0,       0,0,0,0,0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,'h3030,  1'b0,0,1,0,0,0,0,0,0));
`endif
        // reset mid-read drops the read; LS granted right after release
        vecs.push_back(v(0,1,'h50,0,0,0,0,0,0,    1,0,0,0,1,0,'h50,'hF,0));
        vecs.push_back(v(1,0,0,0,0,0,0,0,0,       0,0,0,0,0,0,0,0,0));
        vecs.push_back(v(0,0,0,1,1,'h80,'hA5A5A5A5,'hF,'h77,
                         0,1,0,0,1,1,'h80,'hF,'hA5A5A5A5));
        vecs.push_back(v(0,0,0,0,0,0,0,0,'h77,    0,0,0,0,0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,0,       0,0,0,0,0,0,0,0,0));

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst          = vecs[i].rst;
            a.if_req_i   = vecs[i].ifr;
            a.if_addr_i  = vecs[i].ifa;
            a.ls_req_i   = vecs[i].lsr;
            a.ls_we_i    = vecs[i].lswe;
            a.ls_addr_i  = vecs[i].lsa;
            a.ls_wdata_i = vecs[i].lswd;
            a.ls_be_i    = vecs[i].lsbe;
            a.mem_rdata_i = vecs[i].mrd;
            #3;
            chk_addr = vecs[i].mreq | vecs[i].rst;
            chk_wd   = vecs[i].mwe | vecs[i].rst;
            act_b = {a.if_gnt_o, a.ls_gnt_o, a.if_rvalid_o, a.ls_rvalid_o,
                     a.mem_req_o, a.mem_we_o,
                     chk_addr ? a.mem_addr_o : 32'h0,
                     chk_addr ? a.mem_be_o : 4'h0,
                     chk_wd ? a.mem_wdata_o : 32'h0};
            exp_b = {vecs[i].ifg, vecs[i].lsg, vecs[i].ifv, vecs[i].lsv,
                     vecs[i].mreq, vecs[i].mwe, vecs[i].maddr,
                     vecs[i].mbe, vecs[i].mwd};
            check($sformatf("vec%0d", i), 128'(act_b), 128'(exp_b));
            if (vecs[i].ifv)
                check($sformatf("vec%0d_if_rdata", i),
                      128'(a.if_rdata_o), 128'(vecs[i].mrd));
            if (vecs[i].lsv)
                check($sformatf("vec%0d_ls_rdata", i),
                      128'(a.ls_rdata_o), 128'(vecs[i].mrd));
        end

        // RD_LAT=1: IF held high -> grants 0,2,4 and rvalids 1,3,5
        @(posedge clk);
        #1;
        rst = 0;
        a.if_req_i = 0;
        a.ls_req_i = 0;
        b.if_req_i = 1;
        b.if_addr_i = 'h400;
        for (int c = 0; c < 6; c++) begin
            b.mem_rdata_i = 32'h1000 + 32'(c);
            #3;
            check($sformatf("lat1_c%0d_gnt", c),
                  128'(b.if_gnt_o), 128'((c % 2) == 0));
            check($sformatf("lat1_c%0d_rvalid", c),
                  128'(b.if_rvalid_o), 128'((c % 2) == 1));
            check($sformatf("lat1_c%0d_overlap", c),
                  128'(b.if_gnt_o && b.if_rvalid_o), 128'(0));
            if ((c % 2) == 1)
                check($sformatf("lat1_c%0d_rdata", c),
                      128'(b.if_rdata_o), 128'(32'h1000 + 32'(c)));
            @(posedge clk);
            #1;
        end
        b.if_req_i = 0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
